// File: rtl/ft_bus_arbiter.sv
// ft_bus_arbiter: two-channel write scheduler for the FT601 245-style
// master FIFO bus. Pulls words from two FWFT FIFO read ports, grants the
// bus to one channel per burst and drives registered DATA/BE/WR_N with
// TXE_N back-pressure.
// Optional build macro FT_ARB_CH1_PRIO_EN: channel 1 wins every arbitration
// it is present for; otherwise channels alternate round robin.

module ft_bus_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] ch0_data_in,
  input  logic              ch0_valid_in,
  output logic              ch0_rd_out,
  input  logic [DATA_W-1:0] ch1_data_in,
  input  logic              ch1_valid_in,
  output logic              ch1_rd_out,
  input  logic              txe_n_in,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        be_out,
  output logic              wr_n_out,
  output logic              grant_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       burst_cnt;
  logic [1:0]             ch_valid;
  logic [1:0]             ch_rd;
  logic [1:0][DATA_W-1:0] ch_data;
  logic                   accepted;
  logic                   load;
  logic                   pick;

  assign ch_valid   = {ch1_valid_in, ch0_valid_in};
  assign ch_data    = {ch1_data_in, ch0_data_in};
  assign ch0_rd_out = ch_rd[0];
  assign ch1_rd_out = ch_rd[1];
  // the FT601 takes the held word on any edge where it is offered and has room
  assign accepted   = ~wr_n_out & ~txe_n_in;
  assign busy_out   = (state != IDLE);

`ifdef FT_ARB_CH1_PRIO_EN
  // status channel pre-empts the bulk stream at every arbitration
  assign pick = ch_valid[1];
`else
  logic ptr;

  // with both present the pointer decides, otherwise the lone requester wins
  assign pick = (&ch_valid) ? ptr : ch_valid[1];

  // after a completed burst the other channel becomes preferred
  always_ff @(posedge clk_in) begin
    if (!rst_in)
      ptr <= 1'b0;
    else if (state != IDLE && state_nxt == IDLE)
      ptr <= ~grant_out;
  end
`endif

  // next state and pop decision; a stalled word blocks loading so a word is
  // never overwritten before the bus has taken it
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ch_rd     = '0;
    case (state)
      IDLE:  if (|ch_valid) state_nxt = BURST;
      BURST: begin
        if (ch_valid[grant_out] && burst_cnt < MAX_CNT)
          load = wr_n_out | accepted;
        else if (!wr_n_out && !accepted)
          state_nxt = DRAIN;
        else
          state_nxt = IDLE;
      end
      DRAIN: if (accepted) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_in) load = 1'b0;
    ch_rd[grant_out] = load;
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // burst bookkeeping: counter cleared while idle, grant latched at arbitration
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      burst_cnt <= '0;
      grant_out <= 1'b0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
      if (|ch_valid) grant_out <= pick;
    end else if (load) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  // output holding register: load new word, or retire the accepted one
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_out <= '0;
      be_out   <= 4'h0;
      wr_n_out <= 1'b1;
    end else if (load) begin
      data_out <= ch_data[grant_out];
      be_out   <= 4'hF;
      wr_n_out <= 1'b0;
    end else if (accepted) begin
      be_out   <= 4'h0;
      wr_n_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// Bench for ft_bus_arbiter: FIFO sources modelled as queues, per-channel
// expected-word scoreboard checked by a negedge monitor, arbitration model
// kept as plain pointer/priority rules.

module tb_ft_bus_arbiter;

  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int CW   = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [DW-1:0] ch0_data_in, ch1_data_in;
  logic          ch0_valid_in, ch1_valid_in;
  logic          ch0_rd_out, ch1_rd_out;
  logic          txe_n_in;
  logic [DW-1:0] data_out;
  logic [3:0]    be_out;
  logic          wr_n_out, grant_out, busy_out;

  ft_bus_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .ch0_data_in(ch0_data_in), .ch0_valid_in(ch0_valid_in), .ch0_rd_out(ch0_rd_out),
    .ch1_data_in(ch1_data_in), .ch1_valid_in(ch1_valid_in), .ch1_rd_out(ch1_rd_out),
    .txe_n_in(txe_n_in), .data_out(data_out), .be_out(be_out),
    .wr_n_out(wr_n_out), .grant_out(grant_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  // source FIFO contents and expected accepted words, per channel
  logic [DW-1:0] src0[$], src1[$], exp0[$], exp1[$];
  logic gate0 = 1'b0, gate1 = 1'b0, txe_v = 1'b1, rnd = 1'b0;
  logic pop0_s = 1'b0, pop1_s = 1'b0;
  int   pc0 = 0, pc1 = 0, ac0 = 0, ac1 = 0, bcnt = 0;
  logic busy_prev = 1'b0, pv0 = 1'b0, pv1 = 1'b0, ptr_m = 1'b0, cur_ch = 1'b0;
  int   log_ch[$], log_len[$];

  task automatic chk(input string nm, input longint unsigned a, input longint unsigned e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
  endtask

  task automatic enq(input bit ch, input logic [DW-1:0] w);
    if (ch) begin src1.push_back(w); exp1.push_back(w); end
    else    begin src0.push_back(w); exp0.push_back(w); end
  endtask

  task automatic drive();
    ch0_valid_in = gate0 && (src0.size() > 0);
    ch0_data_in  = (src0.size() > 0) ? src0[0] : '0;
    ch1_valid_in = gate1 && (src1.size() > 0);
    ch1_data_in  = (src1.size() > 0) ? src1[0] : '0;
    txe_n_in     = txe_v;
  endtask

  // one clock: retire popped heads, optionally randomise, drive inputs
  task automatic step();
    @(posedge clk_in);
    #1;
    if (pop0_s && src0.size() > 0) src0.delete(0);
    if (pop1_s && src1.size() > 0) src1.delete(0);
    if (rnd) begin
      gate0 = ($urandom_range(0, 3) != 0);
      gate1 = ($urandom_range(0, 3) != 0);
      txe_v = ($urandom_range(0, 2) == 0);
      if (src0.size() < 6 && $urandom_range(0, 2) == 0) enq(1'b0, $urandom);
      if (src1.size() < 6 && $urandom_range(0, 2) == 0) enq(1'b1, $urandom);
    end
    drive();
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && !busy_out && wr_n_out) && n < bound) begin
      step();
      n++;
    end
    chk(nm, n < bound, 1);
  endtask

  task automatic wait_word(input string nm, input logic [DW-1:0] w);
    int n;
    n = 0;
    do begin step(); n++; end while (!(!wr_n_out && data_out == w) && n < 20);
    chk(nm, (!wr_n_out && data_out == w), 1);
  endtask

  // monitor: arbitration model, pop rules, scoreboard on accepted words
  always @(negedge clk_in) begin : mon
    logic bad, eg;
    if (!rst_in) begin
      chk("rst_no_pop", {ch1_rd_out, ch0_rd_out}, 0);
      // popped-but-unaccepted words are lost to the reset
      while (pc0 > ac0 && exp0.size() > 0) begin exp0.delete(0); pc0--; end
      while (pc1 > ac1 && exp1.size() > 0) begin exp1.delete(0); pc1--; end
      pc0 = ac0; pc1 = ac1;
      pop0_s = 1'b0; pop1_s = 1'b0; ptr_m = 1'b0;
      busy_prev = 1'b0; pv0 = 1'b0; pv1 = 1'b0; bcnt = 0;
    end else begin
      pop0_s = ch0_rd_out;
      pop1_s = ch1_rd_out;
      if (ch0_rd_out) pc0++;
      if (ch1_rd_out) pc1++;
      if (busy_prev && !busy_out) begin
        log_ch.push_back(int'(grant_out));
        log_len.push_back(bcnt);
        chk("burst_len_max", bcnt <= MAXB, 1);
        ptr_m = ~cur_ch;
      end
      if (!busy_prev && (pv0 || pv1)) begin
`ifdef FT_ARB_CH1_PRIO_EN
        eg = pv1;
`else
        eg = (pv0 && pv1) ? ptr_m : pv1;
`endif
        chk("arb_leaves_idle", busy_out, 1);
        chk("arb_grant", grant_out, eg);
        cur_ch = eg;
        bcnt = 0;
      end
      bad = (ch0_rd_out && ch1_rd_out) || (!busy_out && (ch0_rd_out || ch1_rd_out)) ||
            (cur_ch ? ch0_rd_out : ch1_rd_out) ||
            (!wr_n_out && txe_n_in && (ch0_rd_out || ch1_rd_out)) ||
            (ch0_rd_out && !ch0_valid_in) || (ch1_rd_out && !ch1_valid_in);
      chk("pop_rule", bad, 0);
      if (wr_n_out) chk("idle_be", be_out, 0);
      else if (!txe_n_in) begin
        chk("accept_be", be_out, 4'hF);
        if (cur_ch) begin
          chk("sb_nonempty_ch1", exp1.size() > 0, 1);
          if (exp1.size() > 0) begin chk("accept_word_ch1", data_out, exp1[0]); exp1.delete(0); end
          ac1++;
        end else begin
          chk("sb_nonempty_ch0", exp0.size() > 0, 1);
          if (exp0.size() > 0) begin chk("accept_word_ch0", data_out, exp0[0]); exp0.delete(0); end
          ac0++;
        end
        bcnt++;
      end
      busy_prev = busy_out;
      pv0 = ch0_valid_in;
      pv1 = ch1_valid_in;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int first, lows, lastl, p0, s, ech;
    logic [DW-1:0] seen[$];
    rst_in = 1'b0;
    drive();
    repeat (3) step();
    chk("rst_data", data_out, 0);
    chk("rst_be", be_out, 0);
    chk("rst_wr_n", wr_n_out, 1);
    chk("rst_rd", {ch1_rd_out, ch0_rd_out}, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_grant", grant_out, 0);
    rst_in = 1'b1;
    step();

    // three-word ch0 burst
    first = -1; lows = 0; lastl = -1; p0 = pc0;
    enq(1'b0, 32'hA0); enq(1'b0, 32'hA1); enq(1'b0, 32'hA2);
    gate0 = 1'b1; gate1 = 1'b1; txe_v = 1'b0; drive();
    for (int i = 0; i < 12; i++) begin
      step();
      if (!wr_n_out) begin
        if (first < 0) first = i;
        lastl = i; lows++;
        seen.push_back(data_out);
        chk("t1_grant", grant_out, 0);
      end
    end
    chk("t1_wr_cycles", lows, 3);
    chk("t1_contig", lastl - first, 2);
    for (int i = 0; i < 3; i++)
      chk("t1_word", (seen.size() > i) ? seen[i] : '0, 32'hA0 + i);
    chk("t1_pops", pc0 - p0, 3);
    chk("t1_idle", busy_out, 0);

    // five-cycle stall on 0x1234
    enq(1'b0, 32'h1111); enq(1'b0, 32'h1234); enq(1'b0, 32'h5678); drive();
    wait_word("t2_reach", 32'h1234);
    txe_v = 1'b1; drive(); p0 = pc0;
    repeat (4) begin
      step();
      chk("t2_hold_data", data_out, 32'h1234);
      chk("t2_hold_wr", wr_n_out, 0);
    end
    step();
    chk("t2_hold_data", data_out, 32'h1234);
    chk("t2_no_pop", pc0 - p0, 0);
    txe_v = 1'b0; drive();
    step();
    chk("t2_next_word", data_out, 32'h5678);
    chk("t2_next_wr", wr_n_out, 0);
    wait_idle("t2_idle", 50);

    // last word stalled: DRAIN refuses new words, then returns to IDLE
    enq(1'b0, 32'hB0); enq(1'b0, 32'hB1); drive();
    wait_word("t3_reach", 32'hB1);
    txe_v = 1'b1; drive();
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin enq(1'b0, 32'hC0); drive(); end
      chk("t3_hold_data", data_out, 32'hB1);
      chk("t3_hold_wr", wr_n_out, 0);
      chk("t3_hold_busy", busy_out, 1);
    end
    txe_v = 1'b0; drive();
    step();
    chk("t3_drain_exit_wr", wr_n_out, 1);
    chk("t3_drain_exit_busy", busy_out, 0);
    wait_idle("t3_idle", 50);

    // reset mid-burst with a held word
    for (int i = 0; i < 6; i++) enq(1'b0, 32'hD0 + i);
    drive();
    wait_word("t4_reach", 32'hD2);
    rst_in = 1'b0; txe_v = 1'b1; drive();
    step();
    chk("t4_rst_wr", wr_n_out, 1);
    chk("t4_rst_be", be_out, 0);
    chk("t4_rst_busy", busy_out, 0);
    chk("t4_rst_data", data_out, 0);
    chk("t4_rst_grant", grant_out, 0);
    chk("t4_rst_rd", {ch1_rd_out, ch0_rd_out}, 0);
    rst_in = 1'b1; txe_v = 1'b0; enq(1'b1, 32'hE0); drive();
    step();
    chk("t4_restart_busy", busy_out, 1);
    chk("t4_ptr_reset_grant", grant_out, 0);
    wait_idle("t4_idle", 100);

    // both channels saturated with bursts capped at MAXB
    rst_in = 1'b0; step(); rst_in = 1'b1; step();
    s = log_ch.size();
    for (int i = 0; i < 12; i++) begin enq(1'b0, 32'hC000 + i); enq(1'b1, 32'hD000 + i); end
    drive();
    wait_idle("t5_idle", 300);
    step(); step();
    chk("t5_bursts", (log_ch.size() - s) >= 4, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef FT_ARB_CH1_PRIO_EN
      ech = (i < 3) ? 1 : 0;
`else
      ech = i % 2;
`endif
      if (log_ch.size() > s + i) begin
        chk("t5_burst_ch", log_ch[s+i], ech);
        chk("t5_burst_len", log_len[s+i], MAXB);
      end
    end

    // random valid/txe patterns
    rnd = 1'b1;
    repeat (10000) step();
    rnd = 1'b0; gate0 = 1'b1; gate1 = 1'b1; txe_v = 1'b0; drive();
    wait_idle("rnd_drain", 2000);
    step(); step();
    chk("exp0_empty", exp0.size(), 0);
    chk("exp1_empty", exp1.size(), 0);
    chk("ch0_pops_vs_accepts", pc0, ac0);
    chk("ch1_pops_vs_accepts", pc1, ac1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
